// File: rtl/okwire_pkg.sv
// Shared host-interface definitions: wire width, Wire Out address window and
// the commit sequencer state encoding.
package okwire_pkg;

    localparam int unsigned OK_WIRE_W = 16;
    localparam logic [7:0]  OK_WIREOUT_ADDR_MIN = 8'h20;
    localparam logic [7:0]  OK_WIREOUT_ADDR_MAX = 8'h3F;

    typedef enum logic {
        ACCEPT = 1'b0,
        COMMIT = 1'b1
    } seq_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request at or after
// the pointer, plus the winner index. Reusable by other host-interface schedulers.
module rr_arbiter
    import okwire_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned RR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [RR_W-1:0]    rr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [RR_W-1:0]    win_o
);

    logic            found;
    logic [RR_W-1:0] k;

    always_comb begin
        gnt_o = '0;
        win_o = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            k = RR_W'((int'(32'(rr_i)) + i) % int'(NUM_REQ));
            if (!found && req_i[k]) begin
                gnt_o[k] = 1'b1;
                win_o    = k;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wireout_commit_sequencer.sv
// Shares a bank of Wire Out endpoints among requesters; staged words commit
// atomically outside ti_wireupdate cycles. Optional stats: WIREOUT_SEQ_STATS_EN.
module wireout_commit_sequencer
    import okwire_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_WIRES = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h20,
    localparam int unsigned IDX_W    = idx_width(NUM_WIRES)
) (
    input  logic                           ti_clock,
    input  logic                           ti_reset,
    input  logic                           ti_wireupdate,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*IDX_W-1:0]       req_index,
    input  logic [NUM_REQ*OK_WIRE_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_WIRES*OK_WIRE_W-1:0] wire_data,
    output logic                           commit_pending,
    output logic [15:0]                    stat_commits,
    output logic [15:0]                    stat_defers
);

    localparam int unsigned RR_W = idx_width(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 8 || NUM_WIRES < 1 || NUM_WIRES > 32 ||
        BASE_ADDR < OK_WIREOUT_ADDR_MIN ||
        (int'(32'(BASE_ADDR)) + int'(NUM_WIRES) - 1) > int'(32'(OK_WIREOUT_ADDR_MAX))) begin : g_bad_cfg
        $error("wireout_commit_sequencer: parameters outside the Wire Out window");
    end

    seq_state_t           state_q, state_d;
    logic [RR_W-1:0]      rr_q;
    logic [RR_W-1:0]      win;
    logic [NUM_REQ-1:0]   gnt;
    logic [OK_WIRE_W-1:0] staging_q [NUM_WIRES];
    logic [OK_WIRE_W-1:0] live_q    [NUM_WIRES];
    logic [NUM_WIRES-1:0] dirty_q;
    logic                 xfer;
    logic                 do_commit;
    logic [IDX_W-1:0]     w_idx;
    logic [OK_WIRE_W-1:0] w_data;
    logic                 w_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .rr_i  (rr_q),
        .gnt_o (gnt),
        .win_o (win)
    );

    // Winning requester's payload and the two events that touch the banks.
    always_comb begin
        w_idx     = req_index[32'(win)*IDX_W +: IDX_W];
        w_data    = req_data[32'(win)*OK_WIRE_W +: OK_WIRE_W];
        w_last    = req_last[win];
        xfer      = (state_q == ACCEPT) && (|(req_valid & req_ready));
        do_commit = (state_q == COMMIT) && !ti_wireupdate;
    end

    always_ff @(posedge ti_clock) begin
        if (ti_reset) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT:  if (xfer && w_last) state_d = COMMIT;
            COMMIT:  if (!ti_wireupdate) state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    always_comb begin
        req_ready      = '0;
        commit_pending = 1'b0;
        if (!ti_reset && state_q == ACCEPT) req_ready = gnt;
        if (state_q == COMMIT) commit_pending = 1'b1;
    end

    // Out-of-range indices complete the handshake but leave the banks alone.
    always_ff @(posedge ti_clock) begin
        if (ti_reset) begin
            rr_q    <= '0;
            dirty_q <= '0;
            for (int k = 0; k < int'(NUM_WIRES); k++) begin
                staging_q[k] <= '0;
                live_q[k]    <= '0;
            end
        end else begin
            if (xfer) begin
                rr_q <= (32'(win) == NUM_REQ - 1) ? '0 : win + RR_W'(1);
                if (32'(w_idx) < NUM_WIRES) begin
                    staging_q[w_idx] <= w_data;
                    dirty_q[w_idx]   <= 1'b1;
                end
            end
            if (do_commit) begin
                for (int k = 0; k < int'(NUM_WIRES); k++) begin
                    if (dirty_q[k]) live_q[k] <= staging_q[k];
                end
                dirty_q <= '0;
            end
        end
    end

    always_comb begin
        wire_data = '0;
        for (int k = 0; k < int'(NUM_WIRES); k++) begin
            wire_data[k*OK_WIRE_W +: OK_WIRE_W] = live_q[k];
        end
    end

`ifdef WIREOUT_SEQ_STATS_EN
    logic [15:0] commits_q;
    logic [15:0] defers_q;

    // Saturating event counters.
    always_ff @(posedge ti_clock) begin
        if (ti_reset) begin
            commits_q <= '0;
            defers_q  <= '0;
        end else begin
            if (do_commit && commits_q != 16'hFFFF) commits_q <= commits_q + 16'd1;
            if (state_q == COMMIT && ti_wireupdate && defers_q != 16'hFFFF)
                defers_q <= defers_q + 16'd1;
        end
    end

    assign stat_commits = commits_q;
    assign stat_defers  = defers_q;
`else
    assign stat_commits = '0;
    assign stat_defers  = '0;
`endif

endmodule

// File: tb/tb_wireout_commit_sequencer.sv
// Directed self-checking bench for wireout_commit_sequencer (NUM_WIRES=6 so that
// out-of-range indices are reachable).
module tb_wireout_commit_sequencer;

    localparam int NR = 4;
    localparam int NW = 6;
    localparam int IW = 3;
`ifdef WIREOUT_SEQ_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic                ti_clock = 1'b0;
    logic                ti_reset;
    logic                ti_wireupdate;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*IW-1:0]    req_index;
    logic [NR*16-1:0]    req_data;
    logic [NR-1:0]       req_last;
    logic [NW*16-1:0]    wire_data;
    logic                commit_pending;
    logic [15:0]         stat_commits;
    logic [15:0]         stat_defers;

    int errors = 0;
    int checks = 0;

    wireout_commit_sequencer #(.NUM_REQ(NR), .NUM_WIRES(NW), .BASE_ADDR(8'h20)) dut (
        .ti_clock       (ti_clock),
        .ti_reset       (ti_reset),
        .ti_wireupdate  (ti_wireupdate),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_index      (req_index),
        .req_data       (req_data),
        .req_last       (req_last),
        .wire_data      (wire_data),
        .commit_pending (commit_pending),
        .stat_commits   (stat_commits),
        .stat_defers    (stat_defers)
    );

    always #5 ti_clock = ~ti_clock;

    function automatic logic [15:0] wd(input int k);
        return wire_data[k*16 +: 16];
    endfunction

    task automatic cyc();
        @(posedge ti_clock);
        #1;
    endtask

    task automatic set_req(input int r, input int idx, input logic [15:0] d, input logic l);
        req_valid[r]           = 1'b1;
        req_index[r*IW +: IW]  = IW'(idx);
        req_data[r*16 +: 16]   = d;
        req_last[r]            = l;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic do_reset();
        clr_req();
        ti_wireupdate = 1'b0;
        ti_reset = 1'b1;
        cyc();
        ti_reset = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        cyc();
        checks++; if (wire_data !== '0) begin errors++; $display("FAIL reset_wire_data: got %h want 0", wire_data); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
        checks++; if (stat_commits !== 16'd0 || stat_defers !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_commits, stat_defers); end
        clr_req();
        ti_reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_write();
        logic [NW*16-1:0] mask;
        mask = {{(NW*16-16){1'b0}}, 16'hFFFF} << 32;
        set_req(0, 2, 16'hA5A5, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        cyc();
        clr_req();
        req_valid = 4'hF;
        #1;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL single_pending: got %b want 1", commit_pending); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_commit_ready: got %b want 0000", req_ready); end
        checks++; if (wd(2) !== 16'h0000) begin errors++; $display("FAIL single_early: got %h want 0000", wd(2)); end
        cyc();
        clr_req();
        #1;
        checks++; if (wd(2) !== 16'hA5A5) begin errors++; $display("FAIL single_data: got %h want a5a5", wd(2)); end
        checks++; if ((wire_data & ~mask) !== '0) begin errors++; $display("FAIL single_others: got %h want 0 outside slice 2", wire_data); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL single_pending_clr: got %b want 0", commit_pending); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int r = 0; r < NR; r++) set_req(r, r, 16'(16'h1000 + r), 1'b0);
        for (int i = 0; i < NR; i++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << i)) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", i, req_ready, 4'(1 << i)); end
            cyc();
        end
        checks++; if (wire_data !== '0) begin errors++; $display("FAIL contention_no_commit: got %h want 0", wire_data); end
        req_last[0] = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL contention_wrap: got %b want 0001", req_ready); end
        cyc();
        clr_req();
        #1;
        checks++; if (commit_pending !== 1'b1 || wire_data !== '0) begin errors++; $display("FAIL contention_pending: got %b/%h want 1/0", commit_pending, wire_data); end
        cyc();
        for (int k = 0; k < NW; k++) begin
            logic [15:0] exp;
            exp = (k < NR) ? 16'(16'h1000 + k) : 16'h0000;
            checks++; if (wd(k) !== exp) begin errors++; $display("FAIL contention_wire%0d: got %h want %h", k, wd(k), exp); end
        end
    endtask

    task automatic test_deferral();
        do_reset();
        set_req(2, 5, 16'hBEEF, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL defer_grant: got %b want 0100", req_ready); end
        cyc();
        clr_req();
        ti_wireupdate = 1'b1;
        #1;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL defer_pending1: got %b want 1", commit_pending); end
        cyc();
        checks++; if (commit_pending !== 1'b1 || wd(5) !== 16'h0000) begin errors++; $display("FAIL defer_hold1: got %b/%h want 1/0000", commit_pending, wd(5)); end
        cyc();
        ti_wireupdate = 1'b0;
        #1;
        checks++; if (commit_pending !== 1'b1 || wd(5) !== 16'h0000) begin errors++; $display("FAIL defer_hold2: got %b/%h want 1/0000", commit_pending, wd(5)); end
        checks++; if (stat_defers !== 16'(STATS * 2)) begin errors++; $display("FAIL defer_count: got %0d want %0d", stat_defers, STATS * 2); end
        cyc();
        checks++; if (wd(5) !== 16'hBEEF || commit_pending !== 1'b0) begin errors++; $display("FAIL defer_commit: got %h/%b want beef/0", wd(5), commit_pending); end
        checks++; if (stat_commits !== 16'(STATS)) begin errors++; $display("FAIL defer_commits: got %0d want %0d", stat_commits, STATS); end
    endtask

    task automatic test_coherency();
        logic [7:0]  pat;
        logic [31:0] exp;
        pat = 8'b0110_1101;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            clr_req();
            if (i == 0) set_req(1, 0, 16'h1111, 1'b0);
            if (i == 1) set_req(1, 1, 16'h2222, 1'b1);
            ti_wireupdate = pat[i];
            #1;
            if (pat[i]) begin
                exp = (i >= 5) ? 32'h1111_2222 : 32'h0000_0000;
                checks++; if ({wd(0), wd(1)} !== exp) begin errors++; $display("FAIL coherency_cycle%0d: got %h want %h", i, {wd(0), wd(1)}, exp); end
            end
            cyc();
        end
        ti_wireupdate = 1'b0;
    endtask

    task automatic test_boundary();
        do_reset();
        set_req(3, 7, 16'hDEAD, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL oor_grant: got %b want 1000", req_ready); end
        cyc();
        clr_req();
        #1;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL oor_pending: got %b want 1", commit_pending); end
        cyc();
        checks++; if (wire_data !== '0 || commit_pending !== 1'b0) begin errors++; $display("FAIL oor_live: got %h/%b want 0/0", wire_data, commit_pending); end
        set_req(0, 3, 16'h0001, 1'b0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rewrite_grant1: got %b want 0001", req_ready); end
        cyc();
        clr_req();
        set_req(0, 3, 16'h0002, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rewrite_grant2: got %b want 0001", req_ready); end
        cyc();
        clr_req();
        cyc();
        checks++; if (wd(3) !== 16'h0002) begin errors++; $display("FAIL rewrite_last_wins: got %h want 0002", wd(3)); end
        checks++; if (stat_commits !== 16'(STATS * 2)) begin errors++; $display("FAIL boundary_commits: got %0d want %0d", stat_commits, STATS * 2); end
    endtask

    task automatic test_reset_in_commit();
        set_req(3, 1, 16'h7777, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rcommit_grant: got %b want 1000", req_ready); end
        cyc();
        clr_req();
        ti_wireupdate = 1'b1;
        cyc();
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL rcommit_pending: got %b want 1", commit_pending); end
        ti_reset  = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rcommit_reset_ready: got %b want 0000", req_ready); end
        cyc();
        ti_reset      = 1'b0;
        ti_wireupdate = 1'b0;
        #1;
        checks++; if (wire_data !== '0) begin errors++; $display("FAIL rcommit_wire: got %h want 0", wire_data); end
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL rcommit_state: got %b want 0", commit_pending); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rcommit_rr: got %b want 0001", req_ready); end
        checks++; if (stat_commits !== 16'd0 || stat_defers !== 16'd0) begin errors++; $display("FAIL rcommit_stats: got %0d/%0d want 0/0", stat_commits, stat_defers); end
        clr_req();
        cyc();
    endtask

    initial begin
        ti_reset      = 1'b1;
        ti_wireupdate = 1'b0;
        req_valid     = '0;
        req_index     = '0;
        req_data      = '0;
        req_last      = '0;
        cyc();
        cyc();
        test_reset();
        test_single_write();
        test_contention();
        test_deferral();
        test_coherency();
        test_boundary();
        test_reset_in_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wireout_commit_sequencer.md
# wireout_commit_sequencer

Shares a bank of Wire Out endpoints among several user-logic requesters. Requesters post 16-bit words into a staging bank through a round-robin arbiter. A word flagged `last` triggers an atomic commit of all dirty staging words into the live bank. The live bank drives the endpoints' `ep_datain`, and a commit never coincides with a `ti_wireupdate` cycle, so the host always latches a coherent group.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (1–8).
- `NUM_WIRES`, 8: number of managed Wire Out endpoints (1–32).
- `BASE_ADDR`, 8'h20: endpoint address of wire 0. Elaboration error if `BASE_ADDR < 8'h20` or `BASE_ADDR+NUM_WIRES-1 > 8'h3F`.
- `IDX_W`, derived as `$clog2(NUM_WIRES)` (minimum 1): index width.

Ports:
- `ti_clock`  in  1: host-interface clock; single clock domain.
- `ti_reset`  in  1: synchronous, active-high reset.
- `ti_wireupdate`  in  1: host wire-update strobe, same as the endpoints see.
- `req_valid`  in  NUM_REQ: per-requester write request.
- `req_ready`  out  NUM_REQ: per-requester grant (one-hot or zero).
- `req_index`  in  NUM_REQ*IDX_W: target wire index, packed.
- `req_data`  in  NUM_REQ*16: write data, packed.
- `req_last`  in  NUM_REQ: word closes a group and requests a commit.
- `wire_data`  out  NUM_WIRES*16: live bank; slice k feeds `ep_datain` of the endpoint at address `BASE_ADDR+k`.
- `commit_pending`  out  1: high while in COMMIT.
- `stat_commits`  out  16: commit count (see Configuration).
- `stat_defers`  out  16: deferred-commit cycle count (see Configuration).

## Operation
- States: ACCEPT, COMMIT. Reset enters ACCEPT.
- ACCEPT behaviour:
  - Round-robin arbitration among asserted `req_valid`, searching from pointer `rr`.
  - Winner w gets `req_ready[w]=1`; `req_ready` is combinational from `req_valid`, `rr` and state.
  - Transfer occurs when `req_valid[w] & req_ready[w]`.
  - On transfer: `staging[idx] <= data`, `dirty[idx] <= 1`, `rr <= (w+1) mod NUM_REQ`.
- Out-of-range `idx` (≥ NUM_WIRES): the data is dropped, but the handshake still completes and `last` is still honoured.
- Transfer with `last=1`: next state is COMMIT.
- COMMIT behaviour:
  - All `req_ready=0`.
  - If `ti_wireupdate=0`: for every k with `dirty[k]`, `live[k] <= staging[k]`; all dirty bits clear; next state is ACCEPT.
  - If `ti_wireupdate=1`: no change, remain in COMMIT (deferral).
- A commit with no dirty bits is legal and leaves `live` unchanged.
- Repeated writes to the same index before a commit: the last write wins.
- `ti_wireupdate` during ACCEPT has no effect; `live` cannot change in ACCEPT.
- Reset values (`ti_reset=1` at any clock edge, including mid-COMMIT): `live`=0, `staging`=0, `dirty`=0, `rr`=0, state ACCEPT, `req_ready`=0 during the reset cycle, both stats=0.

## Timing
- Transfer in cycle N: staging updated at the end of N.
- `last` transferred in cycle N: COMMIT state and `commit_pending=1` in N+1.
- Without wireupdate in N+1, `wire_data` shows new values from N+2. Each wireupdate cycle while in COMMIT adds one cycle.
- Earliest next grant: N+2.
- Throughput: one word per cycle in ACCEPT.
- `wire_data` is a direct register output with no combinational path from the inputs.

## Configuration
- `WIREOUT_SEQ_STATS_EN` defined:
  - `stat_commits` increments on each executed commit.
  - `stat_defers` increments on each COMMIT cycle with `ti_wireupdate=1`.
  - Both are 16-bit and saturate at 16'hFFFF.
- Undefined: both ports are tied to 0 and no counter logic is generated.

## Structure
- Shared package `okwire_pkg`:
  - `OK_WIRE_W`=16.
  - `OK_WIREOUT_ADDR_MIN`=8'h20, `OK_WIREOUT_ADDR_MAX`=8'h3F.
  - State enum `seq_state_t` {ACCEPT, COMMIT}.
- Sub-module `rr_arbiter`:
  - Parameterised by `NUM_REQ`; inputs are the request vector and `rr`.
  - Outputs are the one-hot grant and the winner index.
  - Reusable by other host-interface schedulers.

## Test plan
- Reset, then single write: req0 writes idx 2 = 16'hA5A5 with `last=1` and no wireupdate → `wire_data[2]`=16'hA5A5 two cycles after the transfer; every other slice reads 0.
- Contention: req0–req3 all valid from `rr`=0, `last=0` → grants in order 0,1,2,3, one per cycle; `wire_data` unchanged until a `last` transfer.
- Deferral: `last` transferred in cycle N; `ti_wireupdate` high in N+1 and N+2 → commit executes in N+3, new data visible in N+4; `stat_defers`=2 with the macro defined.
- Coherency: req1 writes idx0=16'h1111 and idx1=16'h2222 (last on second); host wireupdate in arbitrary cycles → the endpoint-latched pair is always old/old or new/new, never mixed.
- Boundaries: write to idx ≥ NUM_WIRES with `last=1` → handshake completes, commit occurs, `live` unchanged. Two writes to idx 3 (16'h0001 then 16'h0002) before commit → `wire_data[3]`=16'h0002.
- Reset in COMMIT state → `wire_data`=0, `req_ready` resumes the cycle after reset, `rr`=0.
